// File: rtl/comparator_filt.sv
// ============================================================================
// Module   : comparator_filt
// Brief    : Filtered magnitude comparator; commits GT/EQ/LT after HOLD
//            identical samples. Optional macro CMP_EVENT_EN adds event_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module comparator_filt #(
    parameter int WIDTH  = 8,
    parameter int HOLD   = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             led1,
    output logic             led2,
    output logic             led3,
`ifdef CMP_EVENT_EN
    output logic [15:0]      event_cnt,
`endif
    output logic             chg
);

    localparam int             RW     = $clog2(HOLD + 1);
    localparam logic [RW-1:0]  c_hold = RW'(HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STABLE  = 2'd1,
        QUALIFY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cand_q,  cand_d;
    logic [2:0]      leds_q,  leds_d;
    logic [RW-1:0]   run_q,   run_d;
    logic            chg_q,   chg_d;

    logic            w_gt;
    logic            w_lt;
    logic [2:0]      w_raw;
    logic            w_commit;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_gt = $signed(a) > $signed(b);
            assign w_lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign w_gt = a > b;
            assign w_lt = a < b;
        end
    endgenerate

    // Results are one-hot {GT, EQ, LT}, the same layout as the leds.
    assign w_raw    = {w_gt, ~w_gt & ~w_lt, w_lt};
    assign w_commit = (state_q != STABLE) && (run_q == c_hold) && (cand_q != leds_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        leds_d  = leds_q;
        chg_d   = 1'b0;

        if (in_valid) begin
            if (w_raw == cand_q) begin
                if (run_q != c_hold) begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                cand_d = w_raw;
                run_d  = RW'(1);
            end
        end

        // A sample arriving on the commit edge that already disagrees with the
        // new result starts qualifying immediately rather than stalling.
        if (w_commit) begin
            leds_d  = cand_q;
            chg_d   = 1'b1;
            state_d = (in_valid && (w_raw != cand_q)) ? QUALIFY : STABLE;
        end else if (in_valid) begin
            case (state_q)
                IDLE:    state_d = IDLE;
                STABLE:  if (w_raw != leds_q) state_d = QUALIFY;
                QUALIFY: if (w_raw == leds_q) state_d = STABLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 3'b000;
            leds_q  <= 3'b000;
            run_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            leds_q  <= leds_d;
            run_q   <= run_d;
            chg_q   <= chg_d;
        end
    end

`ifdef CMP_EVENT_EN
    logic [15:0] evt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= 16'h0000;
        end else if (w_commit && (evt_q != 16'hFFFF)) begin
            evt_q <= evt_q + 16'h0001;
        end
    end

    assign event_cnt = evt_q;
`endif

    assign led1 = leds_q[2];
    assign led2 = leds_q[1];
    assign led3 = leds_q[0];
    assign chg  = chg_q;

endmodule

`default_nettype wire
